// File: rtl/control_sequencer_if.sv
// Control bus between the hardwired sequencer and the single-bus datapath.
// CTRL_MEM_WAIT_EN adds the mem_rdy handshake input.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        CON_FF;
`ifdef CTRL_MEM_WAIT_EN
  logic        mem_rdy;
`endif
  logic PCout, MARin, IncPC, PCin;
  logic Read, Write, MDRin, MDRout;
  logic IRin, Yin, Zin, Zlowout;
  logic Gra, Grb, Rin, Rout, BAout;
  logic Cout, CONin, R15in;
  logic ADD, Run;

  modport master (
    input  IR, CON_FF,
`ifdef CTRL_MEM_WAIT_EN
    input  mem_rdy,
`endif
    output PCout, MARin, IncPC, PCin,
    output Read, Write, MDRin, MDRout,
    output IRin, Yin, Zin, Zlowout,
    output Gra, Grb, Rin, Rout, BAout,
    output Cout, CONin, R15in, ADD, Run
  );

  modport slave (
    output IR, CON_FF,
`ifdef CTRL_MEM_WAIT_EN
    output mem_rdy,
`endif
    input  PCout, MARin, IncPC, PCin,
    input  Read, Write, MDRin, MDRout,
    input  IRin, Yin, Zin, Zlowout,
    input  Gra, Grb, Rin, Rout, BAout,
    input  Cout, CONin, R15in, ADD, Run
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for the single-bus datapath.
// Optional CTRL_MEM_WAIT_EN stalls memory states on mem_rdy.
module control_sequencer #(
  parameter int OPW = 5
) (
  input  logic                 clk,
  input  logic                 clr,
  control_sequencer_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_BR   = 5'b10010;
  localparam logic [OPW-1:0] OP_JR   = 5'b10011;
  localparam logic [OPW-1:0] OP_JAL  = 5'b10100;
  localparam logic [OPW-1:0] OP_HALT = 5'b11010;

  state_t         state, state_n;
  logic [OPW-1:0] op;
  logic           unused_ir;
  logic           rdy;
  logic is_ld, is_ldi, is_st, is_addi;
  logic is_br, is_jr, is_jal, is_halt;
  logic is_base, is_mem;

  assign op        = bus.IR[31 -: OPW];
  assign unused_ir = ^bus.IR[31-OPW:0];

`ifdef CTRL_MEM_WAIT_EN
  assign rdy = bus.mem_rdy;
`else
  assign rdy = 1'b1;
`endif

  assign is_ld   = (op == OP_LD);
  assign is_ldi  = (op == OP_LDI);
  assign is_st   = (op == OP_ST);
  assign is_addi = (op == OP_ADDI);
  assign is_br   = (op == OP_BR);
  assign is_jr   = (op == OP_JR);
  assign is_jal  = (op == OP_JAL);
  assign is_halt = (op == OP_HALT);
  assign is_mem  = is_ld | is_st;
  assign is_base = is_ldi | is_mem;

  // State register; clr wins over everything, including a stall
  always_ff @(posedge clk) begin
    if (!clr) state <= IDLE;
    else      state <= state_n;
  end

  // Next state and Moore strobe decode of state and opcode
  always_comb begin
    state_n     = state;
    bus.PCout   = 1'b0;
    bus.MARin   = 1'b0;
    bus.IncPC   = 1'b0;
    bus.PCin    = 1'b0;
    bus.Read    = 1'b0;
    bus.Write   = 1'b0;
    bus.MDRin   = 1'b0;
    bus.MDRout  = 1'b0;
    bus.IRin    = 1'b0;
    bus.Yin     = 1'b0;
    bus.Zin     = 1'b0;
    bus.Zlowout = 1'b0;
    bus.Gra     = 1'b0;
    bus.Grb     = 1'b0;
    bus.Rin     = 1'b0;
    bus.Rout    = 1'b0;
    bus.BAout   = 1'b0;
    bus.Cout    = 1'b0;
    bus.CONin   = 1'b0;
    bus.R15in   = 1'b0;
    bus.ADD     = 1'b0;
    bus.Run     = (state != IDLE) && (state != HALT);
    unique case (state)
      IDLE: state_n = T0;
      T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        state_n   = T1;
      end
      T1: begin
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
        if (rdy) state_n = T2;
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_n    = T3;
      end
      T3: begin
        unique case (1'b1)
          is_jal: begin
            bus.PCout = 1'b1;
            bus.R15in = 1'b1;
            state_n   = T4;
          end
          is_jr: begin
            bus.Gra  = 1'b1;
            bus.Rout = 1'b1;
            bus.PCin = 1'b1;
            state_n  = T0;
          end
          is_br: begin
            bus.Gra   = 1'b1;
            bus.Rout  = 1'b1;
            bus.CONin = 1'b1;
            state_n   = T4;
          end
          is_addi: begin
            bus.Grb  = 1'b1;
            bus.Rout = 1'b1;
            bus.Yin  = 1'b1;
            state_n  = T4;
          end
          is_base: begin
            bus.Grb   = 1'b1;
            bus.BAout = 1'b1;
            bus.Yin   = 1'b1;
            state_n   = T4;
          end
          is_halt: state_n = HALT;
          default: state_n = T0;
        endcase
      end
      T4: begin
        unique case (1'b1)
          is_jal: begin
            bus.Gra  = 1'b1;
            bus.Rout = 1'b1;
            bus.PCin = 1'b1;
            state_n  = T0;
          end
          is_br: begin
            bus.PCout = 1'b1;
            bus.Yin   = 1'b1;
            state_n   = T5;
          end
          default: begin
            bus.Cout = 1'b1;
            bus.ADD  = 1'b1;
            bus.Zin  = 1'b1;
            state_n  = T5;
          end
        endcase
      end
      T5: begin
        unique case (1'b1)
          is_br: begin
            bus.Cout = 1'b1;
            bus.ADD  = 1'b1;
            bus.Zin  = 1'b1;
            state_n  = T6;
          end
          is_mem: begin
            bus.Zlowout = 1'b1;
            bus.MARin   = 1'b1;
            state_n     = T6;
          end
          default: begin
            bus.Zlowout = 1'b1;
            bus.Gra     = 1'b1;
            bus.Rin     = 1'b1;
            state_n     = T0;
          end
        endcase
      end
      T6: begin
        unique case (1'b1)
          is_br: begin
            bus.Zlowout = bus.CON_FF;
            bus.PCin    = bus.CON_FF;
            state_n     = T0;
          end
          is_st: begin
            bus.Gra   = 1'b1;
            bus.Rout  = 1'b1;
            bus.MDRin = 1'b1;
            state_n   = T7;
          end
          default: begin
            bus.Read  = 1'b1;
            bus.MDRin = 1'b1;
            if (rdy) state_n = T7;
          end
        endcase
      end
      T7: begin
        if (is_st) begin
          bus.Write = 1'b1;
          if (rdy) state_n = T0;
        end else begin
          bus.MDRout = 1'b1;
          bus.Gra    = 1'b1;
          bus.Rin    = 1'b1;
          state_n    = T0;
        end
      end
      HALT: state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-instruction cycle tables
// plus reset, halt and memory-wait sequences.
module tb_control_sequencer;
  typedef logic [21:0] vec_t;

  localparam vec_t S_PCOUT   = 22'h1 << 21;
  localparam vec_t S_MARIN   = 22'h1 << 20;
  localparam vec_t S_INCPC   = 22'h1 << 19;
  localparam vec_t S_PCIN    = 22'h1 << 18;
  localparam vec_t S_READ    = 22'h1 << 17;
  localparam vec_t S_WRITE   = 22'h1 << 16;
  localparam vec_t S_MDRIN   = 22'h1 << 15;
  localparam vec_t S_MDROUT  = 22'h1 << 14;
  localparam vec_t S_IRIN    = 22'h1 << 13;
  localparam vec_t S_YIN     = 22'h1 << 12;
  localparam vec_t S_ZIN     = 22'h1 << 11;
  localparam vec_t S_ZLOWOUT = 22'h1 << 10;
  localparam vec_t S_GRA     = 22'h1 << 9;
  localparam vec_t S_GRB     = 22'h1 << 8;
  localparam vec_t S_RIN     = 22'h1 << 7;
  localparam vec_t S_ROUT    = 22'h1 << 6;
  localparam vec_t S_BAOUT   = 22'h1 << 5;
  localparam vec_t S_COUT    = 22'h1 << 4;
  localparam vec_t S_CONIN   = 22'h1 << 3;
  localparam vec_t S_R15IN   = 22'h1 << 2;
  localparam vec_t S_ADD     = 22'h1 << 1;
  localparam vec_t S_RUN     = 22'h1;

  localparam vec_t F0 = S_PCOUT | S_MARIN | S_INCPC | S_RUN;
  localparam vec_t F1 = S_READ | S_MDRIN | S_RUN;
  localparam vec_t F2 = S_MDROUT | S_IRIN | S_RUN;
  localparam vec_t ADDR = S_COUT | S_ADD | S_ZIN | S_RUN;
  localparam vec_t BASE = S_GRB | S_BAOUT | S_YIN | S_RUN;

  typedef struct {
    string              name;
    logic [31:0]        ir;
    logic               con;
    int                 len;
    logic [7:0][21:0]   exp;
  } rec_t;

  logic clk;
  logic clr;
  int   checks;
  int   errors;
  rec_t tbl[$];

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t outs();
    return {bus.PCout, bus.MARin, bus.IncPC, bus.PCin,
            bus.Read, bus.Write, bus.MDRin, bus.MDRout,
            bus.IRin, bus.Yin, bus.Zin, bus.Zlowout,
            bus.Gra, bus.Grb, bus.Rin, bus.Rout, bus.BAout,
            bus.Cout, bus.CONin, bus.R15in, bus.ADD, bus.Run};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int cyc,
                       input vec_t exp);
    vec_t got;
    got = outs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %06h expected %06h",
               nm, cyc, got, exp);
    end
  endtask

  task automatic add(input string nm, input logic [31:0] ir,
                     input logic con, input int len,
                     input vec_t e3, input vec_t e4,
                     input vec_t e5, input vec_t e6,
                     input vec_t e7);
    rec_t r;
    r.name = nm;
    r.ir   = ir;
    r.con  = con;
    r.len  = len;
    r.exp  = {e7, e6, e5, e4, e3, F2, F1, F0};
    tbl.push_back(r);
  endtask

  task automatic run_fetch(input string nm);
    check(nm, 0, F0);
    step();
    check(nm, 1, F1);
    step();
    check(nm, 2, F2);
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr = 1'b0;
    bus.IR = 32'h0;
    bus.CON_FF = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
    bus.mem_rdy = 1'b1;
`endif

    add("jal", 32'hA2000000, 1'b1, 5,
        S_PCOUT | S_R15IN | S_RUN,
        S_GRA | S_ROUT | S_PCIN | S_RUN, 0, 0, 0);
    add("br_taken", 32'h93000019, 1'b1, 7,
        S_GRA | S_ROUT | S_CONIN | S_RUN,
        S_PCOUT | S_YIN | S_RUN, ADDR,
        S_ZLOWOUT | S_PCIN | S_RUN, 0);
    add("br_not", 32'h93000019, 1'b0, 7,
        S_GRA | S_ROUT | S_CONIN | S_RUN,
        S_PCOUT | S_YIN | S_RUN, ADDR, S_RUN, 0);
    add("ld", 32'h00900065, 1'b1, 8, BASE, ADDR,
        S_ZLOWOUT | S_MARIN | S_RUN,
        S_READ | S_MDRIN | S_RUN,
        S_MDROUT | S_GRA | S_RIN | S_RUN);
    add("st", 32'h10900065, 1'b0, 8, BASE, ADDR,
        S_ZLOWOUT | S_MARIN | S_RUN,
        S_GRA | S_ROUT | S_MDRIN | S_RUN,
        S_WRITE | S_RUN);
    add("ldi", 32'h08900065, 1'b1, 6, BASE, ADDR,
        S_ZLOWOUT | S_GRA | S_RIN | S_RUN, 0, 0);
    add("addi", 32'h60900065, 1'b0, 6,
        S_GRB | S_ROUT | S_YIN | S_RUN, ADDR,
        S_ZLOWOUT | S_GRA | S_RIN | S_RUN, 0, 0);
    add("jr", 32'h98000000, 1'b1, 4,
        S_GRA | S_ROUT | S_PCIN | S_RUN, 0, 0, 0, 0);
    add("nop", 32'hC8000000, 1'b0, 4, S_RUN, 0, 0, 0, 0);
    add("undef", 32'h28000000, 1'b1, 4, S_RUN, 0, 0, 0, 0);

    step();
    step();
    check("reset_idle", 0, 22'h0);
    clr = 1'b1;
    step();

    foreach (tbl[i]) begin
      bus.IR = tbl[i].ir;
      bus.CON_FF = tbl[i].con;
      for (int c = 0; c < tbl[i].len; c++) begin
        check(tbl[i].name, c, tbl[i].exp[c]);
        step();
      end
    end
    check("back_to_t0", 0, F0);

    bus.IR = 32'h00900065;
    run_fetch("mid_rst");
    check("mid_rst", 3, BASE);
    step();
    check("mid_rst", 4, ADDR);
    step();
    check("mid_rst", 5, S_ZLOWOUT | S_MARIN | S_RUN);
    clr = 1'b0;
    step();
    check("mid_rst_idle", 6, 22'h0);
    clr = 1'b1;
    step();

    bus.IR = 32'hD0000000;
    run_fetch("halt");
    check("halt", 3, S_RUN);
    step();
    for (int k = 0; k < 10; k++) begin
      check("halt_hold", k, 22'h0);
      step();
    end
    clr = 1'b0;
    step();
    check("halt_clr", 0, 22'h0);
    clr = 1'b1;
    step();
    check("halt_restart", 0, F0);

`ifdef CTRL_MEM_WAIT_EN
    bus.IR = 32'h98000000;
    bus.mem_rdy = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      check("wait_t1", k, F1);
      step();
    end
    check("wait_t1", 3, F1);
    bus.mem_rdy = 1'b1;
    step();
    check("wait_t2", 4, F2);
    step();
    check("wait_jr", 5, S_GRA | S_ROUT | S_PCIN | S_RUN);
    step();
    check("wait_t0", 6, F0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
# control_sequencer

- Hardwired control unit for the single-bus datapath.
- Reads the instruction register and the branch condition flip-flop.
- Each cycle, drives the register-transfer control strobes that the datapath testbenches currently drive by hand: fetch, then a per-opcode execute sequence, then back to fetch.
- Sits beside the datapath; its outputs connect one-to-one to the datapath control inputs.

## Interface
Parameters:
- OPW, 5: opcode width; opcode is IR[31:27].

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  synchronous, active-low reset.
- IR  in  32  instruction register contents, sampled combinationally from state T3 onward.
- CON_FF  in  1  branch condition flip-flop output.
- PCout, MARin, IncPC, PCin  out  1 each  PC / MAR strobes.
- Read, Write, MDRin, MDRout  out  1 each  memory / MDR strobes.
- IRin, Yin, Zin, Zlowout  out  1 each  IR, Y and Z register strobes.
- Gra, Grb, Rin, Rout, BAout  out  1 each  register-select and register-file strobes.
- Cout, CONin, R15in  out  1 each  constant, condition-load and link strobes.
- ADD  out  1  forces the ALU to add, for address and offset computations.
- Run  out  1  high while sequencing; low in IDLE and HALT.

## Operation
- States: IDLE, T0–T7, HALT.
- Outputs are Moore decodes of state and IR[31:27].
- Every strobe is high for exactly one cycle unless stated otherwise.
- Fetch, common to all opcodes:
  - T0: PCout, MARin, IncPC. IncPC increments PC in the same edge.
  - T1: Read, MDRin.
  - T2: MDRout, IRin.
- Execute sequences from T3. The last listed step returns to T0.
  - jal 10100: T3 PCout, R15in; T4 Gra, Rout, PCin.
  - jr 10011: T3 Gra, Rout, PCin.
  - br 10010: T3 Gra, Rout, CONin; T4 PCout, Yin; T5 Cout, ADD, Zin; T6 Zlowout and PCin only if CON_FF=1, otherwise no strobes.
  - ldi 00001: T3 Grb, BAout, Yin; T4 Cout, ADD, Zin; T5 Zlowout, Gra, Rin.
  - addi 01100: T3 Grb, Rout, Yin; T4 Cout, ADD, Zin; T5 Zlowout, Gra, Rin.
  - ld 00000: T3–T4 as ldi; T5 Zlowout, MARin; T6 Read, MDRin; T7 MDRout, Gra, Rin.
  - st 00010: T3–T5 as ld; T6 Gra, Rout, MDRin (Read low); T7 Write.
  - nop 11001 and any undefined opcode: T3 no strobes, then T0.
  - halt 11010: T3 no strobes, then HALT. HALT holds all strobes and Run at 0 until clr is asserted.
- CON_FF is sampled only in T6 of br. Its value in any other state is ignored.

## Timing
- Reset:
  - clr=0 at a rising edge forces state to IDLE on that edge, from any state including mid-instruction.
  - While in IDLE, all strobes and Run are 0.
- Release: the first edge with clr=1 moves IDLE→T0. Run=1 from T0.
- Instruction lengths in cycles, including fetch:
  - jr, nop: 4.
  - jal: 5.
  - ldi, addi: 6.
  - br: 7.
  - ld, st: 8.
  - halt: 4, then stays in HALT.
- No two consecutive instructions overlap. T0 of the next instruction immediately follows the last step of the current one.
- IR is stable from T3 until the next T2. Decoding must not use IR during T0–T2.

## Configuration
- Macro: CTRL_MEM_WAIT_EN.
- Defined:
  - Adds input mem_rdy (1 bit).
  - Memory states T1 (fetch), T6 (ld read) and T7 (st write) hold while mem_rdy=0, keeping their strobes asserted.
  - Advance on the first edge with mem_rdy=1.
  - IncPC still pulses only once, in T0.
  - clr overrides a wait.
- Undefined: no mem_rdy port; every memory access completes in one cycle.

## Test plan
- Reset: hold clr=0 for 2 cycles, then release → one IDLE cycle with all outputs and Run at 0, then T0 with PCout=MARin=IncPC=1.
- jal R4 (IR=0xA2000000):
  - T3: PCout=R15in=1.
  - T4: Gra=Rout=PCin=1.
  - Next cycle: T0; 5 cycles total.
- brzr R6,25 (IR=0x93000019), run twice:
  - CON_FF=1 at T6 → Zlowout=PCin=1 in T6.
  - CON_FF=0 → all strobes 0 in T6.
  - Both runs return to T0 after 7 cycles.
- ld R1,0x65(R2) (IR=0x00900065):
  - Read=1 in T1 and T6.
  - MARin=1 in T0 and T5.
  - Gra=Rin=1 only in T7; 8 cycles total.
- Mid-instruction reset and halt:
  - clr=0 in T5 of ld → IDLE next cycle with all strobes 0.
  - halt (IR=0xD0000000) → HALT with Run=0, held for 10 cycles until clr pulses.
- CTRL_MEM_WAIT_EN: mem_rdy=0 for 3 cycles in T1 → Read=MDRin=1 held for 4 cycles total, IncPC=1 only once, T2 follows.
